// File: rtl/sram_arb_pkg.sv
// rtl/sram_arb_pkg.sv - shared source IDs and lock states for the SRAM request arbiter
package sram_arb_pkg;

    typedef logic src_t;

    localparam src_t SRC_INST = 1'b0;
    localparam src_t SRC_DATA = 1'b1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } lock_st_t;

endpackage

// File: rtl/src_fifo.sv
// rtl/src_fifo.sv - order FIFO recording the source of every accepted transaction
module src_fifo
    import sram_arb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_push,
    input  src_t i_push_src,
    input  logic i_pop,
    output logic o_full,
    output logic o_empty,
    output src_t o_head
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    src_t          r_mem [DEPTH];

    logic w_push;
    logic w_pop;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_head  = r_mem[r_rptr];
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= SRC_INST;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= i_push_src;
                r_wptr        <= r_wptr + 1'b1;
            end
            if (w_pop) r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/sram_req_arbiter.sv
// rtl/sram_req_arbiter.sv - shares one SRAM-like port between fetch and load/store masters
module sram_req_arbiter
    import sram_arb_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inst_sram_req,
    input  logic        inst_sram_wr,
    input  logic [3:0]  inst_sram_wstrb,
    input  logic [1:0]  inst_sram_size,
    input  logic [31:0] inst_sram_addr,
    input  logic [31:0] inst_sram_wdata,
    output logic        inst_sram_addr_ok,
    output logic        inst_sram_data_ok,
    output logic [31:0] inst_sram_rdata,
    input  logic        data_sram_req,
    input  logic        data_sram_wr,
    input  logic [3:0]  data_sram_wstrb,
    input  logic [1:0]  data_sram_size,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic        data_sram_addr_ok,
    output logic        data_sram_data_ok,
    output logic [31:0] data_sram_rdata,
    output logic        mem_sram_req,
    output logic        mem_sram_wr,
    output logic [3:0]  mem_sram_wstrb,
    output logic [1:0]  mem_sram_size,
    output logic [31:0] mem_sram_addr,
    output logic [31:0] mem_sram_wdata,
    input  logic        mem_sram_addr_ok,
    input  logic        mem_sram_data_ok,
    input  logic [31:0] mem_sram_rdata,
    output logic        err
);

    localparam int                SW         = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0]     STREAK_MAX = SW'(STARVE_MAX);

    lock_st_t      r_lock;
    lock_st_t      w_lock_nxt;
    src_t          r_lock_src;
    logic [SW-1:0] r_streak;
    logic          r_err;

    logic w_req, w_accept, w_pop, w_full, w_empty;
    logic w_sel_inst, w_sel_data;
    src_t w_src, w_head;

    src_fifo #(.DEPTH(DEPTH)) u_src_fifo (
        .i_clk      (clk),
        .i_reset    (reset),
        .i_push     (w_accept),
        .i_push_src (w_src),
        .i_pop      (w_pop),
        .o_full     (w_full),
        .o_empty    (w_empty),
        .o_head     (w_head)
    );

    // A held request keeps its source so the downstream sees stable fields.
    always_comb begin
        w_req = 1'b0;
        w_src = SRC_INST;
        if (r_lock == ST_HOLD) begin
            w_req = 1'b1;
            w_src = r_lock_src;
        end else if (!w_full) begin
            if (inst_sram_req && r_streak == STREAK_MAX) begin
                w_req = 1'b1;
                w_src = SRC_INST;
            end else if (data_sram_req) begin
                w_req = 1'b1;
                w_src = SRC_DATA;
            end else if (inst_sram_req) begin
                w_req = 1'b1;
                w_src = SRC_INST;
            end
        end
    end

    always_comb begin
        w_lock_nxt = r_lock;
        case (r_lock)
            ST_IDLE: if (w_req && !mem_sram_addr_ok) w_lock_nxt = ST_HOLD;
            ST_HOLD: if (mem_sram_addr_ok)           w_lock_nxt = ST_IDLE;
            default: w_lock_nxt = ST_IDLE;
        endcase
    end

    assign w_accept   = w_req & mem_sram_addr_ok;
    assign w_pop      = mem_sram_data_ok & ~w_empty;
    assign w_sel_inst = w_req & (w_src == SRC_INST);
    assign w_sel_data = w_req & (w_src == SRC_DATA);

    always_comb begin
        mem_sram_wr    = 1'b0;
        mem_sram_wstrb = '0;
        mem_sram_size  = '0;
        mem_sram_addr  = '0;
        mem_sram_wdata = '0;
        if (w_sel_data) begin
            mem_sram_wr    = data_sram_wr;
            mem_sram_wstrb = data_sram_wstrb;
            mem_sram_size  = data_sram_size;
            mem_sram_addr  = data_sram_addr;
            mem_sram_wdata = data_sram_wdata;
        end else if (w_sel_inst) begin
            mem_sram_wr    = inst_sram_wr;
            mem_sram_wstrb = inst_sram_wstrb;
            mem_sram_size  = inst_sram_size;
            mem_sram_addr  = inst_sram_addr;
            mem_sram_wdata = inst_sram_wdata;
        end
    end

    assign mem_sram_req      = w_req;
    assign inst_sram_addr_ok = mem_sram_addr_ok & w_sel_inst;
    assign data_sram_addr_ok = mem_sram_addr_ok & w_sel_data;
    assign inst_sram_data_ok = w_pop & (w_head == SRC_INST);
    assign data_sram_data_ok = w_pop & (w_head == SRC_DATA);
    assign inst_sram_rdata   = inst_sram_data_ok ? mem_sram_rdata : 32'h0;
    assign data_sram_rdata   = data_sram_data_ok ? mem_sram_rdata : 32'h0;
    assign err               = r_err;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_lock     <= ST_IDLE;
            r_lock_src <= SRC_INST;
            r_streak   <= '0;
            r_err      <= 1'b0;
        end else begin
            r_lock <= w_lock_nxt;
            if (r_lock == ST_IDLE && w_lock_nxt == ST_HOLD) r_lock_src <= w_src;
            // Streak counts data wins only while fetch is actually waiting.
            if (!inst_sram_req || (w_accept && w_src == SRC_INST))
                r_streak <= '0;
            else if (w_accept && w_src == SRC_DATA && r_streak != STREAK_MAX)
                r_streak <= r_streak + 1'b1;
            if (mem_sram_data_ok && w_empty) r_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sram_req_arbiter.sv
// tb/tb_sram_req_arbiter.sv - directed self-checking bench for sram_req_arbiter
module tb_sram_req_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_sram_req, inst_sram_wr;
    logic [3:0]  inst_sram_wstrb;
    logic [1:0]  inst_sram_size;
    logic [31:0] inst_sram_addr, inst_sram_wdata;
    logic        inst_sram_addr_ok, inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;
    logic        data_sram_req, data_sram_wr;
    logic [3:0]  data_sram_wstrb;
    logic [1:0]  data_sram_size;
    logic [31:0] data_sram_addr, data_sram_wdata;
    logic        data_sram_addr_ok, data_sram_data_ok;
    logic [31:0] data_sram_rdata;
    logic        mem_sram_req, mem_sram_wr;
    logic [3:0]  mem_sram_wstrb;
    logic [1:0]  mem_sram_size;
    logic [31:0] mem_sram_addr, mem_sram_wdata;
    logic        mem_sram_addr_ok, mem_sram_data_ok;
    logic [31:0] mem_sram_rdata;
    logic        err;

    int checks = 0;
    int errors = 0;

    sram_req_arbiter #(.DEPTH(4), .STARVE_MAX(4)) dut (
        .clk(clk), .reset(reset),
        .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr),
        .inst_sram_wstrb(inst_sram_wstrb), .inst_sram_size(inst_sram_size),
        .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
        .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok),
        .inst_sram_rdata(inst_sram_rdata),
        .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
        .data_sram_wstrb(data_sram_wstrb), .data_sram_size(data_sram_size),
        .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
        .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok),
        .data_sram_rdata(data_sram_rdata),
        .mem_sram_req(mem_sram_req), .mem_sram_wr(mem_sram_wr),
        .mem_sram_wstrb(mem_sram_wstrb), .mem_sram_size(mem_sram_size),
        .mem_sram_addr(mem_sram_addr), .mem_sram_wdata(mem_sram_wdata),
        .mem_sram_addr_ok(mem_sram_addr_ok), .mem_sram_data_ok(mem_sram_data_ok),
        .mem_sram_rdata(mem_sram_rdata),
        .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        inst_sram_req = 0; inst_sram_wr = 0; inst_sram_wstrb = 0; inst_sram_size = 0;
        inst_sram_addr = 0; inst_sram_wdata = 0;
        data_sram_req = 0; data_sram_wr = 0; data_sram_wstrb = 0; data_sram_size = 0;
        data_sram_addr = 0; data_sram_wdata = 0;
        mem_sram_addr_ok = 0; mem_sram_data_ok = 0; mem_sram_rdata = 0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_req"},   {31'h0, mem_sram_req}, 32'h0);
        check({tag, "_addr"},  mem_sram_addr, 32'h0);
        check({tag, "_iaok"},  {31'h0, inst_sram_addr_ok}, 32'h0);
        check({tag, "_daok"},  {31'h0, data_sram_addr_ok}, 32'h0);
        check({tag, "_idok"},  {31'h0, inst_sram_data_ok}, 32'h0);
        check({tag, "_ddok"},  {31'h0, data_sram_data_ok}, 32'h0);
        check({tag, "_err"},   {31'h0, err}, 32'h0);
    endtask

    function automatic logic inst_turn(input int c);
        return (c % 5) == 4;
    endfunction

    initial begin
        idle_inputs();
        reset = 1;
        tick(); tick();
        reset = 0;
        #1;
        check_all_zero("rst");

        // Fetch-only read routed back to fetch
        inst_sram_req = 1; inst_sram_addr = 32'h1C000000; inst_sram_size = 2; mem_sram_addr_ok = 1;
        #1;
        check("t1_req",  {31'h0, mem_sram_req}, 32'h1);
        check("t1_addr", mem_sram_addr, 32'h1C000000);
        check("t1_iaok", {31'h0, inst_sram_addr_ok}, 32'h1);
        check("t1_daok", {31'h0, data_sram_addr_ok}, 32'h0);
        tick();
        idle_inputs();
        #1;
        check("t1_c1_req", {31'h0, mem_sram_req}, 32'h0);
        tick();
        mem_sram_data_ok = 1; mem_sram_rdata = 32'h02800000;
        #1;
        check("t1_idok",  {31'h0, inst_sram_data_ok}, 32'h1);
        check("t1_irdat", inst_sram_rdata, 32'h02800000);
        check("t1_ddok",  {31'h0, data_sram_data_ok}, 32'h0);
        check("t1_drdat", data_sram_rdata, 32'h0);
        tick();
        idle_inputs();

        // Data priority and hold while addr_ok is low
        data_sram_req = 1; data_sram_addr = 32'h100; data_sram_wr = 1;
        data_sram_wstrb = 4'hF; data_sram_wdata = 32'hDEADBEEF;
        #1;
        check("t2_c0_addr",  mem_sram_addr, 32'h100);
        check("t2_c0_wr",    {31'h0, mem_sram_wr}, 32'h1);
        check("t2_c0_wstrb", {28'h0, mem_sram_wstrb}, 32'hF);
        check("t2_c0_wdata", mem_sram_wdata, 32'hDEADBEEF);
        check("t2_c0_daok",  {31'h0, data_sram_addr_ok}, 32'h0);
        tick();
        inst_sram_req = 1; inst_sram_addr = 32'h200;
        #1;
        check("t2_c1_addr", mem_sram_addr, 32'h100);
        tick();
        #1;
        check("t2_c2_addr", mem_sram_addr, 32'h100);
        tick();
        mem_sram_addr_ok = 1;
        #1;
        check("t2_c3_daok", {31'h0, data_sram_addr_ok}, 32'h1);
        check("t2_c3_iaok", {31'h0, inst_sram_addr_ok}, 32'h0);
        tick();
        data_sram_req = 0;
        #1;
        check("t2_c4_addr", mem_sram_addr, 32'h200);
        check("t2_c4_iaok", {31'h0, inst_sram_addr_ok}, 32'h1);
        tick();
        idle_inputs();
        mem_sram_data_ok = 1; mem_sram_rdata = 32'hD1;
        #1;
        check("t2_r0_ddok",  {31'h0, data_sram_data_ok}, 32'h1);
        check("t2_r0_drdat", data_sram_rdata, 32'hD1);
        check("t2_r0_idok",  {31'h0, inst_sram_data_ok}, 32'h0);
        tick();
        mem_sram_rdata = 32'hA1;
        #1;
        check("t2_r1_idok",  {31'h0, inst_sram_data_ok}, 32'h1);
        check("t2_r1_irdat", inst_sram_rdata, 32'hA1);
        tick();
        idle_inputs();

        // Starvation guard: four data wins then one fetch
        data_sram_req = 1; inst_sram_req = 1; mem_sram_addr_ok = 1;
        data_sram_addr = 32'hDA00; inst_sram_addr = 32'h1A00;
        for (int c = 0; c < 10; c++) begin
            mem_sram_data_ok = (c >= 1);
            mem_sram_rdata = 32'h500 + c;
            #1;
            check($sformatf("t3_c%0d_iaok", c), {31'h0, inst_sram_addr_ok}, {31'h0, inst_turn(c)});
            check($sformatf("t3_c%0d_daok", c), {31'h0, data_sram_addr_ok}, {31'h0, !inst_turn(c)});
            if (c >= 1) begin
                check($sformatf("t3_c%0d_idok", c), {31'h0, inst_sram_data_ok}, {31'h0, inst_turn(c - 1)});
                check($sformatf("t3_c%0d_ddok", c), {31'h0, data_sram_data_ok}, {31'h0, !inst_turn(c - 1)});
            end
            tick();
        end
        idle_inputs();
        mem_sram_data_ok = 1; mem_sram_rdata = 32'h50A;
        #1;
        check("t3_last_idok", {31'h0, inst_sram_data_ok}, 32'h1);
        check("t3_last_irdat", inst_sram_rdata, 32'h50A);
        tick();
        idle_inputs();
        #1;
        check("t3_err", {31'h0, err}, 32'h0);

        // Fill the order FIFO with I,D,D,I
        mem_sram_addr_ok = 1;
        inst_sram_req = 1; tick();
        inst_sram_req = 0; data_sram_req = 1; tick();
        tick();
        data_sram_req = 0; inst_sram_req = 1; tick();
        data_sram_req = 1; mem_sram_data_ok = 1; mem_sram_rdata = 32'h11;
        #1;
        check("t4_full_req",  {31'h0, mem_sram_req}, 32'h0);
        check("t4_full_daok", {31'h0, data_sram_addr_ok}, 32'h0);
        check("t4_full_idok", {31'h0, inst_sram_data_ok}, 32'h1);
        tick();
        inst_sram_req = 0; mem_sram_data_ok = 0;
        #1;
        check("t4_resume_req",  {31'h0, mem_sram_req}, 32'h1);
        check("t4_resume_daok", {31'h0, data_sram_addr_ok}, 32'h1);
        tick();
        idle_inputs();
        mem_sram_data_ok = 1;
        for (int k = 0; k < 4; k++) begin
            logic [3:0] order;
            order = 4'b1011;
            mem_sram_rdata = 32'h20 + k;
            #1;
            check($sformatf("t4_drain%0d_ddok", k), {31'h0, data_sram_data_ok}, {31'h0, order[k]});
            check($sformatf("t4_drain%0d_idok", k), {31'h0, inst_sram_data_ok}, {31'h0, !order[k]});
            tick();
        end
        idle_inputs();

        // Response with empty FIFO sets a sticky err
        mem_sram_data_ok = 1;
        #1;
        check("t5_empty_idok", {31'h0, inst_sram_data_ok}, 32'h0);
        check("t5_empty_ddok", {31'h0, data_sram_data_ok}, 32'h0);
        tick();
        mem_sram_data_ok = 0;
        #1;
        check("t5_err_set", {31'h0, err}, 32'h1);
        tick();
        #1;
        check("t5_err_hold", {31'h0, err}, 32'h1);

        // Two outstanding, then reset discards them
        mem_sram_addr_ok = 1; inst_sram_req = 1; tick();
        inst_sram_req = 0; data_sram_req = 1; tick();
        idle_inputs();
        reset = 1;
        tick();
        reset = 0;
        #1;
        check_all_zero("t5_rst");
        mem_sram_data_ok = 1; mem_sram_rdata = 32'h77;
        #1;
        check("t5_stale_idok", {31'h0, inst_sram_data_ok}, 32'h0);
        check("t5_stale_ddok", {31'h0, data_sram_data_ok}, 32'h0);
        tick();
        idle_inputs();
        #1;
        check("t5_stale_err", {31'h0, err}, 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
